// File: rtl/prog_loader_if.sv
// Byte-stream port that carries a program image into prog_loader.
// The source drives the master modport; the loader uses the slave modport.
interface prog_loader_if;
    logic       in_valid;
    logic       in_last;
    logic [7:0] byte_in;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_last,
        output byte_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  byte_in,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Streams a program image into cpu RAM over a valid/ready byte port, then kicks the cpu.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to treat the in_last byte as a checksum.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned AUTO_RUN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      stream,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [7:0]        ld_data,
    output logic              ld_wren,
    output logic              cpu_halt,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              ovf,
`ifdef PROG_LOADER_CHECKSUM_EN
    output logic              csum_err,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int unsigned        CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]   CAP   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0]  BASE  = ADDR_W'(BASE_ADDR);

    // KICK is the second RUN cycle, carrying the cpu_run pulse after the final write.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_LOAD,
        ST_RUN,
        ST_KICK,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_d;
    logic               in_ready_q, in_ready_d;
    logic [ADDR_W-1:0]  ld_addr_d;
    logic [7:0]         ld_data_d;
    logic               ld_wren_d;
    logic               cpu_halt_d;
    logic               cpu_run_d;
    logic               busy_d;
    logic               done_d;
    logic               run_ok;
    logic               accept;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         sum_next;
    logic               csum_bad_q, csum_bad_d;
    logic               csum_err_d;

    assign sum_next = sum_q + stream.byte_in;
`endif

    assign accept          = stream.in_valid && in_ready_q;
    assign stream.in_ready = in_ready_q;

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count;
        ovf_d      = ovf;
        ld_addr_d  = ld_addr;
        ld_data_d  = ld_data;
        ld_wren_d  = 1'b0;
        run_ok     = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        csum_bad_d = csum_bad_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_HALT;
                    ptr_d   = BASE;
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
                    csum_bad_d = 1'b0;
`endif
                end
            end

            ST_HALT: state_d = ST_LOAD;

            ST_LOAD: begin
                if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (stream.in_last) begin
                        // Checksum byte: verified, never written.
                        csum_bad_d = (sum_next != 8'd0);
                        state_d    = ST_RUN;
                    end else
`endif
                    if (count == CAP) begin
                        // Image is full: drop the byte and wait for in_last.
                        ovf_d = 1'b1;
                        if (stream.in_last) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        ld_wren_d = 1'b1;
                        ld_addr_d = ptr_q;
                        ld_data_d = stream.byte_in;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        count_d   = count + CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d     = sum_next;
`endif
                        if (stream.in_last) begin
                            state_d = ST_RUN;
                        end
                    end
                end else if (ovf && stream.in_valid && stream.in_last) begin
                    // in_last still terminates an overflowed load with in_ready low.
                    state_d = ST_DONE;
                end
            end

            ST_RUN:  state_d = ST_KICK;

            ST_KICK: state_d = ST_DONE;

            default: state_d = ST_IDLE;
        endcase

`ifdef PROG_LOADER_CHECKSUM_EN
        run_ok     = !csum_bad_d;
        csum_err_d = (state_d == ST_DONE) && csum_bad_d;
`endif

        // Status outputs follow the state they will be registered alongside.
        in_ready_d = (state_d == ST_LOAD) && !ovf_d;
        busy_d     = (state_d == ST_HALT) || (state_d == ST_LOAD) ||
                     (state_d == ST_RUN)  || (state_d == ST_KICK);
        cpu_halt_d = (state_d == ST_HALT);
        cpu_run_d  = (state_d == ST_KICK) && (AUTO_RUN != 0) && run_ok;
        done_d     = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= BASE;
            count      <= '0;
            ovf        <= 1'b0;
            in_ready_q <= 1'b0;
            ld_addr    <= BASE;
            ld_data    <= 8'd0;
            ld_wren    <= 1'b0;
            cpu_halt   <= 1'b0;
            cpu_run    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
            csum_bad_q <= 1'b0;
            csum_err   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count      <= count_d;
            ovf        <= ovf_d;
            in_ready_q <= in_ready_d;
            ld_addr    <= ld_addr_d;
            ld_data    <= ld_data_d;
            ld_wren    <= ld_wren_d;
            cpu_halt   <= cpu_halt_d;
            cpu_run    <= cpu_run_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            csum_bad_q <= csum_bad_d;
            csum_err   <= csum_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: RAM writes are scoreboarded against a queue of
// expected {addr,data} pushed as bytes are handed over.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_wren;
    logic              cpu_halt;
    logic              cpu_run;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [ADDR_W:0]   count;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic              csum_err;
`endif

    prog_loader_if bus ();

    prog_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(0),
        .AUTO_RUN (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stream  (bus),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ld_wren (ld_wren),
        .cpu_halt(cpu_halt),
        .cpu_run (cpu_run),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
`ifdef PROG_LOADER_CHECKSUM_EN
        .csum_err(csum_err),
`endif
        .count   (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W+7:0] exp_wr[$];
    logic [ADDR_W+7:0] obs_wr[$];
    int                obs_cyc[$];
    int                run_cyc[$];
    int                halt_cyc[$];
    logic [ADDR_W-1:0] exp_ptr;
    int                n_checks;
    int                n_pass;
    int                timeouts;

    // Observed RAM writes and cpu strobes, sampled mid-cycle.
    always @(negedge clk) begin
        if (ld_wren === 1'b1) begin
            obs_wr.push_back({ld_addr, ld_data});
            obs_cyc.push_back(cyc);
        end
        if (cpu_run === 1'b1)  run_cyc.push_back(cyc);
        if (cpu_halt === 1'b1) halt_cyc.push_back(cyc);
    end

    task automatic clear_sb();
        exp_wr.delete();
        obs_wr.delete();
        obs_cyc.delete();
        run_cyc.delete();
        halt_cyc.delete();
        exp_ptr  = '0;
        timeouts = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.byte_in = 8'h00;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    // Offers one byte until accepted; pushes the expected write when wr is set.
    task automatic send_byte(input logic [7:0] b, input logic last, input bit wr);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.byte_in = b;
        bus.in_last = last;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (bus.in_ready !== 1'b1) timeouts++;
        else if (wr) begin
            exp_wr.push_back({exp_ptr, b});
            exp_ptr++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (done !== 1'b1 && k < bound) begin
            idle(1);
            k++;
        end
        if (done !== 1'b1) timeouts++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ld_wren, cpu_halt, cpu_run, busy, done, ovf, bus.in_ready} !== 7'b0)
            $display("FAIL reset_flags got %b want 0000000",
                     {ld_wren, cpu_halt, cpu_run, busy, done, ovf, bus.in_ready});
        else n_pass++;
        n_checks++;
        if ({ld_addr, ld_data} !== 16'h0000)
            $display("FAIL reset_ld got %h want 0000", {ld_addr, ld_data});
        else n_pass++;
        n_checks++;
        if (count !== 9'd0) $display("FAIL reset_count got %0d want 0", count);
        else n_pass++;
        // Bytes offered while IDLE must not be consumed.
        clear_sb();
        bus.in_valid = 1'b1;
        bus.byte_in = 8'hEE;
        bus.in_last = 1'b1;
        idle(3);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        n_checks++;
        if ({obs_wr.size() != 0, done, busy} !== 3'b000)
            $display("FAIL idle_ignore got writes=%0d done=%b busy=%b want 0 0 0",
                     obs_wr.size(), done, busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [ADDR_W+7:0] e, o;
        int last_w, run0;
        clear_sb();
        do_start();
        n_checks++;
        if ({cpu_halt, busy, bus.in_ready} !== 3'b110)
            $display("FAIL basic_halt got %b want 110", {cpu_halt, busy, bus.in_ready});
        else n_pass++;
        send_byte(8'h02, 1'b0, 1'b1);
        send_byte(8'h05, 1'b0, 1'b1);
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h09, 1'b1, 1'b1);
        wait_done(20);
        last_w = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : -100;
        run0   = (run_cyc.size() > 0) ? run_cyc[0] : -1;
        n_checks++;
        if (obs_wr.size() !== exp_wr.size())
            $display("FAIL basic_nwrites got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL basic_write got %h want %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if ({halt_cyc.size(), run_cyc.size()} !== {32'd1, 32'd1})
            $display("FAIL basic_pulses got halt=%0d run=%0d want 1 1",
                     halt_cyc.size(), run_cyc.size());
        else n_pass++;
        n_checks++;
        if (run0 !== last_w + 1)
            $display("FAIL basic_run_timing got cycle %0d want %0d", run0, last_w + 1);
        else n_pass++;
        n_checks++;
        if ({done, busy, ovf, count} !== {3'b100, 9'd4})
            $display("FAIL basic_status got done=%b busy=%b ovf=%b count=%0d want 1 0 0 4",
                     done, busy, ovf, count);
        else n_pass++;
        n_checks++;
        if (timeouts !== 0) $display("FAIL basic_timeout got %0d want 0", timeouts);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [ADDR_W+7:0] e, o;
        int span;
        logic [7:0] pat[8];
        pat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        clear_sb();
        do_start();
        for (int i = 0; i < 4; i++) send_byte(pat[i], 1'b0, 1'b1);
        idle(3);
        for (int i = 4; i < 8; i++) send_byte(pat[i], (i == 7), 1'b1);
        wait_done(20);
        span = (obs_cyc.size() == 8) ? obs_cyc[7] - obs_cyc[0] : -1;
        n_checks++;
        if (obs_wr.size() !== exp_wr.size())
            $display("FAIL stall_nwrites got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL stall_write got %h want %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if (span !== 10) $display("FAIL stall_span got %0d want 10", span);
        else n_pass++;
        n_checks++;
        if ({run_cyc.size(), count} !== {32'd1, 9'd8})
            $display("FAIL stall_end got run=%0d count=%0d want 1 8", run_cyc.size(), count);
        else n_pass++;
        n_checks++;
        if (timeouts !== 0) $display("FAIL stall_timeout got %0d want 0", timeouts);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [ADDR_W+7:0] e, o;
        int bad;
        clear_sb();
        do_start();
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'hA5, 1'b0, 1'b1);
        send_byte(8'h77, 1'b1, 1'b0);
        wait_done(20);
        n_checks++;
        if (obs_wr.size() !== 256)
            $display("FAIL ovf_nwrites got %0d want 256", obs_wr.size());
        else n_pass++;
        bad = 0;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_checks++;
            if (o !== e) begin
                if (bad < 4) $display("FAIL ovf_write got %h want %h", o, e);
                bad++;
            end else n_pass++;
        end
        n_checks++;
        if ({ovf, done, busy, bus.in_ready} !== 4'b1100)
            $display("FAIL ovf_status got ovf=%b done=%b busy=%b rdy=%b want 1 1 0 0",
                     ovf, done, busy, bus.in_ready);
        else n_pass++;
        n_checks++;
        if (count !== 9'd256) $display("FAIL ovf_count got %0d want 256", count);
        else n_pass++;
        n_checks++;
        if (run_cyc.size() !== 0) $display("FAIL ovf_no_run got %0d pulses want 0", run_cyc.size());
        else n_pass++;
        n_checks++;
        if (timeouts !== 0) $display("FAIL ovf_timeout got %0d want 0", timeouts);
        else n_pass++;
    endtask

    task automatic test_rst_mid_load();
        logic [ADDR_W+7:0] e, o;
        clear_sb();
        do_start();
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.byte_in = 8'h33;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if ({ld_wren, cpu_halt, cpu_run, busy, done, ovf, bus.in_ready} !== 7'b0)
            $display("FAIL rst_flags got %b want 0000000",
                     {ld_wren, cpu_halt, cpu_run, busy, done, ovf, bus.in_ready});
        else n_pass++;
        n_checks++;
        if ({ld_addr, ld_data, count} !== 25'd0)
            $display("FAIL rst_regs got addr=%h data=%h count=%0d want 0 0 0",
                     ld_addr, ld_data, count);
        else n_pass++;
        clear_sb();
        do_start();
        n_checks++;
        if (count !== 9'd0) $display("FAIL rst_restart_count got %0d want 0", count);
        else n_pass++;
        send_byte(8'h44, 1'b0, 1'b1);
        send_byte(8'h55, 1'b1, 1'b1);
        wait_done(20);
        n_checks++;
        if (obs_wr.size() !== exp_wr.size())
            $display("FAIL rst_nwrites got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL rst_write got %h want %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if ({count, timeouts != 0} !== {9'd2, 1'b0})
            $display("FAIL rst_end got count=%0d timeouts=%0d want 2 0", count, timeouts);
        else n_pass++;
    endtask

    task automatic test_start_in_load();
        logic [ADDR_W+7:0] e, o;
        clear_sb();
        do_start();
        send_byte(8'h61, 1'b0, 1'b1);
        send_byte(8'h62, 1'b0, 1'b1);
        do_start();
        send_byte(8'h63, 1'b0, 1'b1);
        send_byte(8'h64, 1'b1, 1'b1);
        wait_done(20);
        n_checks++;
        if (obs_wr.size() !== exp_wr.size())
            $display("FAIL sil_nwrites got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL sil_write got %h want %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if ({count, halt_cyc.size(), run_cyc.size()} !== {9'd4, 32'd1, 32'd1})
            $display("FAIL sil_end got count=%0d halt=%0d run=%0d want 4 1 1",
                     count, halt_cyc.size(), run_cyc.size());
        else n_pass++;
        n_checks++;
        if (timeouts !== 0) $display("FAIL sil_timeout got %0d want 0", timeouts);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W+7:0] e, o;
        clear_sb();
        do_start();
        n_checks++;
        if ({done, busy, count} !== {2'b01, 9'd0})
            $display("FAIL b2b_clear got done=%b busy=%b count=%0d want 0 1 0", done, busy, count);
        else n_pass++;
        send_byte(8'h7E, 1'b1, 1'b1);
        wait_done(20);
        n_checks++;
        if (obs_wr.size() !== exp_wr.size())
            $display("FAIL b2b_nwrites got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL b2b_write got %h want %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if ({count, run_cyc.size(), timeouts} !== {9'd1, 32'd1, 32'd0})
            $display("FAIL b2b_end got count=%0d run=%0d timeouts=%0d want 1 1 0",
                     count, run_cyc.size(), timeouts);
        else n_pass++;
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [ADDR_W+7:0] e, o;
        logic [7:0] ck[2];
        ck = '{8'hD0, 8'hD1};
        for (int t = 0; t < 2; t++) begin
            clear_sb();
            do_start();
            send_byte(8'h10, 1'b0, 1'b1);
            send_byte(8'h20, 1'b0, 1'b1);
            send_byte(ck[t], 1'b1, 1'b0);
            wait_done(20);
            n_checks++;
            if (obs_wr.size() !== exp_wr.size())
                $display("FAIL csum_nwrites got %0d want %0d", obs_wr.size(), exp_wr.size());
            else n_pass++;
            while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
                e = exp_wr.pop_front();
                o = obs_wr.pop_front();
                n_checks++;
                if (o !== e) $display("FAIL csum_write got %h want %h", o, e);
                else n_pass++;
            end
            n_checks++;
            if ({csum_err, run_cyc.size()} !== {(t == 1), (t == 1) ? 32'd0 : 32'd1})
                $display("FAIL csum_result got err=%b run=%0d for ck=%h", csum_err,
                         run_cyc.size(), ck[t]);
            else n_pass++;
            n_checks++;
            if (timeouts !== 0) $display("FAIL csum_timeout got %0d want 0", timeouts);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass = 0;
        timeouts = 0;
        exp_ptr = '0;
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.byte_in = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_rst_mid_load();
        test_start_in_load();
        test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
